// File: rtl/ssd_mux_driver.sv
// ssd_mux_driver: 4-digit multiplexed seven-segment driver showing SS.hh from BCD inputs
module ssd_mux_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] milli,
  input  logic [7:0] sec,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [3:0] AN_X = {4{ACTIVE_LOW}};
  localparam logic [6:0] SEG_X = {7{ACTIVE_LOW}};
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_snap;
  logic          w_wrap;
  logic          w_on;
  logic [3:0]    w_dig;
  logic [6:0]    w_dec;
  assign w_wrap = r_cnt == CW'(REFRESH_DIV - 1);
  assign w_dig  = r_snap[{r_idx, 2'b00} +: 4];
  // The guard window at the start of every slot keeps the previous digit from ghosting.
  assign w_on   = (r_cnt >= CW'(GUARD)) && !(blank_lz && r_idx == 2'd3 && r_snap[15:12] == 4'd0);
  always_comb begin
    w_dec = 7'h40;
    case (w_dig)
      4'd0: w_dec = 7'h3F;
      4'd1: w_dec = 7'h06;
      4'd2: w_dec = 7'h5B;
      4'd3: w_dec = 7'h4F;
      4'd4: w_dec = 7'h66;
      4'd5: w_dec = 7'h6D;
      4'd6: w_dec = 7'h7D;
      4'd7: w_dec = 7'h07;
      4'd8: w_dec = 7'h7F;
      4'd9: w_dec = 7'h6F;
      default: w_dec = 7'h40;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_idx  <= 2'd0;
      r_snap <= 16'd0;
      an     <= AN_X;
      seg    <= SEG_X;
      dp     <= ACTIVE_LOW;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) r_idx <= r_idx + 2'd1;
      // One snapshot per scan so a single refresh never mixes two input values.
      if (r_idx == 2'd0 && r_cnt == '0) r_snap <= {sec, milli};
      an  <= (w_on ? 4'b0001 << r_idx : 4'b0000) ^ AN_X;
      seg <= (w_on ? w_dec : 7'h00) ^ SEG_X;
      dp  <= (w_on && r_idx == 2'd2) ^ ACTIVE_LOW;
    end
  end
endmodule
